axis_ram_reader: RTL and testbench
==================================

# axis_ram_reader

Streams a circular region of DDR memory out as an AXI4-Stream by issuing fixed 16-beat AXI3 INCR read bursts.
- It is the read-side counterpart of the RAM writer: same base-address/burst-index addressing, same 16-beat bursts, same AXI3 HP-port attachment.
- It sits between a Zynq HP slave port and a DAC/stream consumer.
- An internal FIFO decouples bursts from the consumer. Bursts are issued only when FIFO space for the whole burst is guaranteed, so the R channel is never back-pressured.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of the burst index; the region is 2^ADDR_WIDTH bursts.
- AXI_ID_WIDTH, 6, AXI ID width.
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 64, AXI data width; equals the stream width; power of two, 8..1024.
- FIFO_DEPTH, 512, FIFO depth in words; power of two, ≥ 32.
- MAX_OUTSTANDING, 4, maximum number of issued-but-incomplete bursts; 1..15.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- cfg_data  in  AXI_ADDR_WIDTH  region base byte address; must be aligned to 2^(ADDR_WIDTH+4+ADDR_SIZE).
- sts_data  out  ADDR_WIDTH  index of the next burst to issue.
- sts_error  out  1  sticky RLAST/beat-count mismatch flag.
- m_axi_arid  out  AXI_ID_WIDTH  constant 0.
- m_axi_arlen  out  4  constant 15.
- m_axi_arsize  out  3  constant ADDR_SIZE = log2(AXI_DATA_WIDTH/8).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arcache  out  4  constant 4'b0110.
- m_axi_araddr  out  AXI_ADDR_WIDTH  burst start address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  AXI_DATA_WIDTH  read data.
- m_axi_rlast  in  1  last beat of a burst.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  constant 1 once out of reset.
- m_axis_tdata  out  AXI_DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.

## Operation
- **Address generation**
  - The burst counter `idx` (ADDR_WIDTH bits) is 0 after reset.
  - m_axi_araddr = cfg_data + {idx, 4'b0, ADDR_SIZE'b0}, computed modulo 2^AXI_ADDR_WIDTH.
  - `idx` increments on each AR handshake. It wraps from 2^ADDR_WIDTH-1 to 0, so reading is endlessly circular.
- **Credit accounting**
  - `cnt` = words currently held in the FIFO. It increments on each R beat and decrements on each stream handshake; a beat and a handshake in the same cycle leave it unchanged.
  - `out` = outstanding bursts. It increments on an AR handshake and decrements on an R beat with rlast=1; both in the same cycle leave it unchanged.
  - A burst is issued when all of these hold: arvalid=0, out < MAX_OUTSTANDING, and cnt + 16·out + 16 ≤ FIFO_DEPTH. Issuing sets arvalid and latches araddr.
  - Consequence: the FIFO can never overflow, so rready is held at 1.
- **AR state machine**
  - IDLE: if the issue condition holds, go to REQ with arvalid=1.
  - REQ: hold araddr and arvalid stable until arready. On the handshake, update `idx` and `out` and return to IDLE.
  - There is no back-to-back AR issue; the minimum spacing between AR handshakes is 2 cycles.
- **Beat check**
  - A 4-bit beat counter counts R beats and wraps every 16.
  - sts_error is set and held until reset if either occurs:
    - rlast=1 on a beat whose counter value is ≠ 15;
    - rlast=0 on a beat whose counter value is 15.
  - Data is forwarded regardless of the error. rresp is not monitored.
- **Stream output**
  - The FIFO is first-word-fall-through: tvalid = FIFO not empty.
  - Data leaves in exactly the R-beat arrival order.
- **Status**: sts_data = `idx`.

## Timing
- **Reset (areset=1, takes effect immediately)**
  - Outputs: m_axi_arvalid=0, m_axi_araddr=0, m_axi_rready=0, m_axis_tvalid=0, sts_data=0, sts_error=0.
  - Internal state: cnt=0, out=0, beat counter=0, FIFO flushed.
- **Reset mid-operation**
  - Outstanding R beats that arrive after reset release are not expected. The system requirement is that the AXI interconnect is reset together with this block.
- **First read after reset release**: arvalid rises on the 1st rising edge after areset falls.
- **R to stream latency**
  - A beat accepted at edge N is visible on m_axis no later than edge N+3.
  - After that, one word per cycle is sustained while the FIFO is non-empty and tready=1.
- **Stream handshake**
  - tdata/tvalid stay stable while tvalid=1 and tready=0.
  - tready may toggle freely.
- **Throughput**: with tready=1 and zero-latency memory, the AR issue rate is ≥ 1 burst per 16 cycles, so no stream bubbles occur after the initial fill.
- **FIFO boundaries**
  - Full: with tready held 0, issuing stops once cnt + 16·out > FIFO_DEPTH − 16. With FIFO_DEPTH=512, exactly 32 bursts are read (cnt = 512).
  - Empty: tvalid deasserts in the cycle after the last word's handshake.

## Test plan
- Base address and sequence:
  - Stimulus: reset, cfg_data=0x1000_0000, memory model with word k = k, tready=1.
  - Required response: araddr sequence 0x1000_0000, 0x1000_0080, 0x1000_0100, …; stream carries 0,1,2,… with no gaps after fill.
- Wrap-around:
  - Stimulus: ADDR_WIDTH=2.
  - Required response: the 5th araddr equals cfg_data; sts_data sequence 0,1,2,3,0.
- Back-pressure:
  - Stimulus: tready=0 throughout, FIFO_DEPTH=512.
  - Required response: exactly 32 AR handshakes; rready never drops while a beat is pending; tvalid=1 holding word 0 unchanged.
- Random stall:
  - Stimulus: random tready at 30 % duty, random arready/rvalid delays, 10 000 words.
  - Required response: stream equals the memory order exactly; out never exceeds MAX_OUTSTANDING.
- RLAST error:
  - Stimulus: the memory model asserts rlast on beat 14 of burst 3.
  - Required response: sts_error=1 from the next cycle and stays 1 until areset; data is still forwarded.
- Asynchronous reset mid-stream:
  - Stimulus: assert areset between clock edges during a burst.
  - Required response: arvalid, tvalid and sts_data become 0 immediately without a clock edge; after release, arvalid rises on the 1st edge with araddr = cfg_data.

Source files
------------

// File: rtl/axis_ram_reader.sv
// axis_ram_reader: streams a circular DDR region out as AXI4-Stream using
// 16-beat AXI3 INCR reads; cfg_data=base, sts_data=next burst, sts_error=RLAST fault.
module axis_ram_reader #(
  parameter int ADDR_WIDTH      = 16,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH      = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_data,
  output logic [ADDR_WIDTH-1:0]     sts_data,
  output logic                      sts_error,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [3:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [3:0]                m_axi_arcache,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int ADDR_SIZE = $clog2(AXI_DATA_WIDTH / 8);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]     idx;
  logic [3:0]                out;
  logic [CW-1:0]             cnt;
  logic [3:0]                beat;
  logic                      error;
  logic                      rready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [AXI_ADDR_WIDTH-1:0] offset;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [31:0]               need;
  logic                      space;
  logic                      issue;
  logic                      ar_done;
  logic                      r_beat;
  logic                      r_end;
  logic                      s_take;

  assign r_beat = m_axi_rvalid & rready;
  assign r_end  = r_beat & m_axi_rlast;
  assign s_take = m_axis_tvalid & m_axis_tready;

  // Reserve room for every outstanding burst plus the new one, so
  // the R channel never needs back-pressure.
  assign need  = 32'(cnt) + {24'd0, out, 4'd0} + 32'd16;
  assign space = (need <= 32'(FIFO_DEPTH))
              && (out < 4'(MAX_OUTSTANDING));

  assign offset = AXI_ADDR_WIDTH'(idx) << (4 + ADDR_SIZE);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    ar_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (space) begin
          issue      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (m_axi_arready) begin
          ar_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      idx    <= '0;
      out    <= '0;
      cnt    <= '0;
      beat   <= '0;
      error  <= 1'b0;
      rready <= 1'b0;
      araddr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_next;
      rready <= 1'b1;
      if (issue)
        araddr <= cfg_data + offset;
      if (ar_done)
        idx <= idx + ADDR_WIDTH'(1);
      if (ar_done && !r_end)
        out <= out + 4'd1;
      else if (!ar_done && r_end)
        out <= out - 4'd1;
      if (r_beat && !s_take)
        cnt <= cnt + CW'(1);
      else if (!r_beat && s_take)
        cnt <= cnt - CW'(1);
      if (r_beat) begin
        wr_ptr <= wr_ptr + PW'(1);
        beat   <= beat + 4'd1;
        // RLAST must coincide exactly with the 16th beat.
        if (m_axi_rlast != (beat == 4'd15))
          error <= 1'b1;
      end
      if (s_take)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (r_beat)
      mem[wr_ptr] <= m_axi_rdata;
  end

  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 4'd15;
  assign m_axi_arsize  = 3'(ADDR_SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0110;
  assign m_axi_araddr  = araddr;
  assign m_axi_arvalid = (state == REQ);
  assign m_axi_rready  = rready;
  assign m_axis_tdata  = mem[rd_ptr];
  assign m_axis_tvalid = (cnt != '0);
  assign sts_data      = idx;
  assign sts_error     = error;

endmodule

// File: tb/tb_axis_ram_reader.sv
// tb_axis_ram_reader: directed checks of axis_ram_reader against an
// AXI3 read-slave model whose word k holds value k (region of 4 bursts).
module tb_axis_ram_reader;

  localparam int AW  = 2;
  localparam int IDW = 6;
  localparam int AAW = 32;
  localparam int DW  = 64;
  localparam int FD  = 512;
  localparam int MO  = 4;

  logic           clk = 1'b0;
  logic           areset;
  logic [AAW-1:0] cfg_data;
  logic [AW-1:0]  sts_data;
  logic           sts_error;
  logic [IDW-1:0] arid;
  logic [3:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic [3:0]     arcache;
  logic [AAW-1:0] araddr;
  logic           arvalid;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic           rlast;
  logic           rvalid;
  logic           rready;
  logic [DW-1:0]  tdata;
  logic           tvalid;
  logic           tready;

  always #5 clk = ~clk;

  axis_ram_reader #(
    .ADDR_WIDTH(AW),
    .AXI_ID_WIDTH(IDW),
    .AXI_ADDR_WIDTH(AAW),
    .AXI_DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(clk),
    .areset(areset),
    .cfg_data(cfg_data),
    .sts_data(sts_data),
    .sts_error(sts_error),
    .m_axi_arid(arid),
    .m_axi_arlen(arlen),
    .m_axi_arsize(arsize),
    .m_axi_arburst(arburst),
    .m_axi_arcache(arcache),
    .m_axi_araddr(araddr),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata),
    .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // slave model state and logs
  logic [31:0] ar_q[$];
  logic [31:0] ar_log[$];
  int          sts_log[$];
  int          ar_cyc[$];
  logic [63:0] rx[$];
  int          s_cyc[$];
  int          r_beat, burst_num;
  int          ar_pct = 100;
  int          r_pct = 100;
  int          tmode = 0;
  logic        tready_val = 1'b1;
  bit          inject = 1'b0;
  bit          p_ar, p_r, p_s, p_rinj;
  logic [31:0] c_addr;
  int          c_sts;
  logic [63:0] c_data;
  int          r_first, max_out, rready_drop, hold_bad;
  bit          prev_hold, inj_seen;
  logic [63:0] prev_data;
  logic        err_before, err_after;

  // Inputs change on negedge; handshakes flagged here complete on
  // the following posedge and are logged at the next negedge.
  initial begin : slave
    arready = 0; rvalid = 0; rdata = 0; rlast = 0; tready = 0;
    forever begin
      @(negedge clk);
      if (areset) begin
        ar_q.delete(); ar_log.delete(); sts_log.delete();
        ar_cyc.delete(); rx.delete(); s_cyc.delete();
        r_beat = 0; burst_num = 0;
        p_ar = 0; p_r = 0; p_s = 0; p_rinj = 0;
        prev_hold = 0; inj_seen = 0;
        r_first = -1; max_out = 0;
        rready_drop = 0; hold_bad = 0;
        arready = 0; rvalid = 0; rlast = 0; tready = 0;
      end else begin
        if (p_ar) begin
          ar_q.push_back(c_addr);
          ar_log.push_back(c_addr);
          sts_log.push_back(c_sts);
          ar_cyc.push_back(cyc);
        end
        if (p_r) begin
          if (r_first < 0) r_first = cyc;
          if (p_rinj) begin
            inj_seen = 1;
            err_after = sts_error;
          end
          if (r_beat == 15) begin
            r_beat = 0;
            burst_num++;
            ar_q.delete(0);
          end else r_beat++;
        end
        if (p_s) begin
          rx.push_back(c_data);
          s_cyc.push_back(cyc);
        end
        if (prev_hold && (tvalid !== 1'b1 || tdata !== prev_data))
          hold_bad++;
        if (ar_q.size() > max_out) max_out = ar_q.size();
        arready = (int'($urandom_range(99)) < ar_pct);
        if (ar_q.size() > 0 && int'($urandom_range(99)) < r_pct) begin
          rvalid = 1;
          rdata = 64'((ar_q[0] - cfg_data) >> 3) + 64'(r_beat);
          rlast = (r_beat == 15)
               || (inject && burst_num == 3 && r_beat == 14);
        end else begin
          rvalid = 0;
          rlast = 0;
        end
        tready = (tmode != 0) ? (int'($urandom_range(99)) < 30)
                              : tready_val;
        p_ar = arvalid && arready;
        c_addr = araddr;
        c_sts = int'(sts_data);
        p_r = rvalid && rready;
        p_rinj = p_r && rlast && (r_beat != 15);
        if (p_rinj) err_before = sts_error;
        if (rvalid && !rready) rready_drop++;
        p_s = tvalid && tready;
        c_data = tdata;
        prev_hold = tvalid && !tready;
        prev_data = tdata;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    areset = 1;
    repeat (3) tick();
    areset = 0;
  endtask

  task automatic test_reset;
    cfg_data = 32'h1000_0000;
    ar_pct = 100; r_pct = 100; tmode = 0; tready_val = 1;
    areset = 1;
    repeat (3) tick();
    checks++;
    if (arvalid !== 1'b0) begin
      errors++; $display("FAIL rst_arvalid got %b exp 0", arvalid);
    end
    checks++;
    if (araddr !== 32'h0) begin
      errors++; $display("FAIL rst_araddr got %h exp 0", araddr);
    end
    checks++;
    if (rready !== 1'b0) begin
      errors++; $display("FAIL rst_rready got %b exp 0", rready);
    end
    checks++;
    if (tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_tvalid got %b exp 0", tvalid);
    end
    checks++;
    if (sts_data !== 2'd0 || sts_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_sts got %h/%b exp 0/0", sts_data, sts_error);
    end
    checks++;
    if (arlen !== 4'd15 || arsize !== 3'd3 || arburst !== 2'b01
        || arcache !== 4'b0110 || arid !== 6'd0) begin
      errors++;
      $display("FAIL ar_const got %h %h %h %h %h exp f 3 1 6 0",
               arlen, arsize, arburst, arcache, arid);
    end
    areset = 0;
    tick();
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1000_0000) begin
      errors++;
      $display("FAIL first_ar got %b/%h exp 1/10000000", arvalid, araddr);
    end
  endtask

  task automatic test_sequence;
    logic [31:0] exp_a [5];
    int exp_s [5];
    int n, bad;
    exp_a = '{32'h1000_0000, 32'h1000_0080, 32'h1000_0100,
              32'h1000_0180, 32'h1000_0000};
    exp_s = '{0, 1, 2, 3, 0};
    cfg_data = 32'h1000_0000;
    ar_pct = 100; r_pct = 100; tmode = 0; tready_val = 1;
    do_reset();
    n = 0;
    while (rx.size() < 200 && n < 3000) begin tick(); n++; end
    checks++;
    if (rx.size() < 200) begin
      errors++; $display("FAIL seq_timeout got %0d exp 200", rx.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ar_log[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL seq_araddr%0d got %h exp %h", i, ar_log[i], exp_a[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (sts_log[i] != exp_s[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL seq_sts got %0d bad exp 0", bad);
    end
    bad = 0;
    for (int k = 0; k < 200 && k < rx.size(); k++)
      if (rx[k] !== 64'(k % 64)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL seq_data got %0d bad exp 0", bad);
    end
    bad = 0;
    for (int k = 1; k < 200 && k < s_cyc.size(); k++)
      if (s_cyc[k] - s_cyc[k-1] != 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL seq_gaps got %0d exp 0", bad);
    end
    checks++;
    if (s_cyc.size() == 0 || s_cyc[0] - r_first > 3
        || s_cyc[0] - r_first < 1) begin
      errors++;
      $display("FAIL seq_latency got %0d exp 1..3",
               (s_cyc.size() > 0) ? s_cyc[0] - r_first : -1);
    end
    bad = 0;
    for (int k = 1; k < ar_cyc.size(); k++)
      if (ar_cyc[k] - ar_cyc[k-1] < 2) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL seq_ar_spacing got %0d exp 0", bad);
    end
  endtask

  task automatic test_backpressure;
    int n, bad;
    cfg_data = 32'h1000_0000;
    ar_pct = 100; r_pct = 100; tmode = 0; tready_val = 0;
    do_reset();
    bad = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (tvalid === 1'b1 && tdata !== 64'd0) bad++;
    end
    checks++;
    if (ar_log.size() != 32) begin
      errors++; $display("FAIL bp_ar_count got %0d exp 32", ar_log.size());
    end
    checks++;
    if (rready_drop != 0) begin
      errors++; $display("FAIL bp_rready got %0d drops exp 0", rready_drop);
    end
    checks++;
    if (tvalid !== 1'b1 || tdata !== 64'd0 || bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %b/%h bad %0d exp 1/0 bad 0",
               tvalid, tdata, bad);
    end
    checks++;
    if (max_out != 4) begin
      errors++; $display("FAIL bp_max_out got %0d exp 4", max_out);
    end
    checks++;
    if (sts_data !== 2'd0) begin
      errors++; $display("FAIL bp_sts got %0d exp 0", sts_data);
    end
    ar_pct = 0;
    tick();
    tready_val = 1;
    n = 0;
    while (rx.size() < 512 && n < 1000) begin tick(); n++; end
    checks++;
    if (rx.size() != 512 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got %0d/%b exp 512/0", rx.size(), tvalid);
    end
    bad = 0;
    for (int k = 0; k < rx.size(); k++)
      if (rx[k] !== 64'(k % 64)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_data got %0d bad exp 0", bad);
    end
    tready_val = 1; ar_pct = 100;
  endtask

  task automatic test_random;
    int n, bad;
    cfg_data = 32'h2000_0000;
    ar_pct = 50; r_pct = 60; tmode = 1;
    do_reset();
    n = 0;
    while (rx.size() < 10000 && n < 60000) begin tick(); n++; end
    checks++;
    if (rx.size() < 10000) begin
      errors++; $display("FAIL rnd_timeout got %0d exp 10000", rx.size());
    end
    bad = 0;
    for (int k = 0; k < rx.size(); k++)
      if (rx[k] !== 64'(k % 64)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rnd_data got %0d bad exp 0", bad);
    end
    checks++;
    if (max_out > 4) begin
      errors++; $display("FAIL rnd_max_out got %0d exp <=4", max_out);
    end
    checks++;
    if (rready_drop != 0 || hold_bad != 0) begin
      errors++;
      $display("FAIL rnd_handshake got %0d/%0d exp 0/0",
               rready_drop, hold_bad);
    end
    tmode = 0; ar_pct = 100; r_pct = 100;
  endtask

  task automatic test_rlast_error;
    int n, bad;
    cfg_data = 32'h1000_0000;
    ar_pct = 100; r_pct = 100; tmode = 0; tready_val = 1;
    inject = 1;
    do_reset();
    n = 0;
    while (!inj_seen && n < 500) begin tick(); n++; end
    checks++;
    if (!inj_seen || err_before !== 1'b0 || err_after !== 1'b1) begin
      errors++;
      $display("FAIL err_set got seen %b %b->%b exp 1 0->1",
               inj_seen, err_before, err_after);
    end
    n = 0;
    while (rx.size() < 64 && n < 500) begin tick(); n++; end
    repeat (50) tick();
    checks++;
    if (sts_error !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b exp 1", sts_error);
    end
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (k >= rx.size() || rx[k] !== 64'(k % 64)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL err_data got %0d bad exp 0", bad);
    end
    inject = 0;
  endtask

  task automatic test_async_reset;
    int n;
    cfg_data = 32'h1000_0000;
    ar_pct = 100; r_pct = 100; tmode = 0; tready_val = 1;
    do_reset();
    n = 0;
    while (!(tvalid === 1'b1 && sts_data != 0) && n < 200) begin
      tick(); n++;
    end
    checks++;
    if (tvalid !== 1'b1 || sts_data == 0) begin
      errors++;
      $display("FAIL ar_mid got %b/%0d exp 1/nonzero", tvalid, sts_data);
    end
    #2;
    areset = 1;
    #1;
    checks++;
    if (arvalid !== 1'b0 || tvalid !== 1'b0 || sts_data !== 2'd0
        || rready !== 1'b0) begin
      errors++;
      $display("FAIL async_clear got %b %b %0d %b exp 0 0 0 0",
               arvalid, tvalid, sts_data, rready);
    end
    repeat (2) tick();
    areset = 0;
    tick();
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1000_0000) begin
      errors++;
      $display("FAIL async_restart got %b/%h exp 1/10000000",
               arvalid, araddr);
    end
    n = 0;
    while (rx.size() < 20 && n < 300) begin tick(); n++; end
    checks++;
    if (rx.size() < 20 || rx[0] !== 64'd0 || rx[19] !== 64'd19) begin
      errors++;
      $display("FAIL async_data got %0d words exp 20 from 0", rx.size());
    end
  endtask

  initial begin
    areset = 0;
    cfg_data = 32'h0;
    #1;
    test_reset();
    test_sequence();
    test_backpressure();
    test_random();
    test_rlast_error();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
